// File: rtl/mem_write_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Types and defaults shared by the memory read and write
//                controllers: default bus widths, the write-request record,
//                the write-side FSM state type and a saturating increment.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int c_def_addr_w = 8;
    localparam int c_def_data_w = 8;
    localparam int c_drop_cnt_w = 8;

    typedef struct packed {
        logic [c_def_addr_w-1:0] addr;
        logic [c_def_data_w-1:0] data;
    } wr_req_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

    // Saturating increment for the drop counter.
    function automatic logic [c_drop_cnt_w-1:0] sat_inc(input logic [c_drop_cnt_w-1:0] v);
        return (v == {c_drop_cnt_w{1'b1}}) ? v : v + c_drop_cnt_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_write_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_write_control_if
//  Description : Requester and memory-side signals of the write controller.
//                master : environment view (drives requests and mem_ack)
//                slave  : controller view
//                Requester : wr_en, addr, wdata -> ; <- wr_ready
//                Memory    : <- mem_we, mem_addr, mem_wdata ; mem_ack ->
//                Status    : <- busy, drop_cnt
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_write_control_if #(
    parameter int ADDR_W = mem_ctrl_pkg::c_def_addr_w,
    parameter int DATA_W = mem_ctrl_pkg::c_def_data_w
);
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              busy;
    logic [7:0]        drop_cnt;

    modport master (
        output wr_en, addr, wdata, mem_ack,
        input  wr_ready, mem_we, mem_addr, mem_wdata, busy, drop_cnt
    );

    modport slave (
        input  wr_en, addr, wdata, mem_ack,
        output wr_ready, mem_we, mem_addr, mem_wdata, busy, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_write_control_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, DEPTH a power of two. Occupancy counter is
//                one bit wider than the pointers so full and empty differ.
//                No bypass: a push into an empty FIFO is visible next cycle.
//                Ports: clk, rst_n (sync, active-low), i_push/i_din,
//                i_pop/o_dout (head, combinational), o_full, o_empty, o_count.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only slots behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule
`default_nettype wire

// File: rtl/mem_write_control.sv
`default_nettype none
// ============================================================================
//  Module      : mem_write_control
//  Description : Buffers single-beat write requests in a FIFO and drains them
//                to an SRAM-style port with a we/ack handshake. Requests
//                arriving while the FIFO is full are dropped and counted.
//                Ports: clk, rst_n (sync, active-low), bus (slave modport of
//                mem_write_control_if: request, memory and status signals).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_write_control
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_def_addr_w,
    parameter int DATA_W = c_def_data_w,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_write_control_if.slave bus
);
    localparam int c_req_w = ADDR_W + DATA_W;

    wr_state_e             r_state;
    wr_state_e             w_state_nxt;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [7:0]            r_drop_cnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [c_req_w-1:0]    w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                  w_mem_we;

    // wr_ready comes from the registered count only, so a full FIFO never
    // accepts a push even when the same cycle pops.
    assign w_push = bus.wr_en && !w_full;

    sync_fifo #(
        .WIDTH (c_req_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({bus.addr, bus.wdata}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A pop always loads the output registers; in WRITE it replaces the
    // acknowledged entry so mem_we stays high for back-to-back writes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    if (!w_empty) w_pop       = 1'b1;
                    else          w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_mem_addr  <= w_head[c_req_w-1:DATA_W];
                r_mem_wdata <= w_head[DATA_W-1:0];
            end
            if (bus.wr_en && w_full) r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    assign w_mem_we      = (r_state == WRITE);
    assign bus.wr_ready  = !w_full;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (w_count != '0) || w_mem_we;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_mem_write_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_write_control
//  Description : Self-checking bench for mem_write_control. A queue-based
//                transaction model predicts FIFO occupancy, the write being
//                presented and the drop count; a scoreboard checks every
//                completed write against acceptance order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_write_control;
    import mem_ctrl_pkg::*;

    localparam int c_depth = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_write_control_if #(.ADDR_W(8), .DATA_W(8)) bus();

    mem_write_control #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (c_depth)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int      n_checks = 0;
    int      n_errors = 0;
    wr_req_t m_fifo[$];
    wr_req_t m_sb[$];
    wr_req_t m_cur;
    logic    m_inflight;
    int      m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, score completions, advance model at posedge, compare.
    task automatic cycle(input logic we, input logic [7:0] a, input logic [7:0] d,
                         input logic ack, input logic rstn);
        wr_req_t req;
        wr_req_t done;
        int      pre;
        @(negedge clk);
        bus.wr_en   = we;
        bus.addr    = a;
        bus.wdata   = d;
        bus.mem_ack = ack;
        rst_n       = rstn;
        #1;
        if (rstn && bus.mem_we && ack) begin
            if (m_sb.size() == 0) begin
                check("spurious_write", 32'(bus.mem_we), 32'd0);
            end else begin
                done = m_sb.pop_front();
                check("order_addr", 32'(bus.mem_addr), 32'(done.addr));
                check("order_data", 32'(bus.mem_wdata), 32'(done.data));
            end
        end
        @(posedge clk);
        if (!rstn) begin
            m_fifo.delete();
            m_sb.delete();
            m_cur      = '0;
            m_inflight = 1'b0;
            m_drop     = 0;
        end else begin
            pre = m_fifo.size();
            if (!m_inflight) begin
                if (pre > 0) begin
                    m_cur      = m_fifo.pop_front();
                    m_inflight = 1'b1;
                end
            end else if (ack) begin
                if (pre > 0) m_cur = m_fifo.pop_front();
                else         m_inflight = 1'b0;
            end
            if (we) begin
                if (pre < c_depth) begin
                    req.addr = a;
                    req.data = d;
                    m_fifo.push_back(req);
                    m_sb.push_back(req);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
        #1;
        check("wr_ready",  32'(bus.wr_ready),  32'(m_fifo.size() < c_depth));
        check("mem_we",    32'(bus.mem_we),    32'(m_inflight));
        check("mem_addr",  32'(bus.mem_addr),  32'(m_cur.addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(m_cur.data));
        check("busy",      32'(bus.busy),      32'((m_fifo.size() != 0) || m_inflight));
        check("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.mem_ack = 1'b0;
        m_cur       = '0;
        m_inflight  = 1'b0;
        m_drop      = 0;

        // Reset held with wr_en asserted
        repeat (4) cycle(1'b1, 8'h55, 8'h66, 1'b1, 1'b0);

        // Single write, ack tied high
        cycle(1'b1, 8'd2, 8'hA5, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);

        // Back-to-back burst
        cycle(1'b1, 8'd2,  8'h11, 1'b1, 1'b1);
        cycle(1'b1, 8'd11, 8'h22, 1'b1, 1'b1);
        cycle(1'b1, 8'd1,  8'h33, 1'b1, 1'b1);
        cycle(1'b1, 8'd13, 8'h44, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);

        // Fill with memory stalled, overflow drops, then drain
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 8'(8'h20 + i), 8'($urandom), 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);

        // Long stall on a write to address 13
        cycle(1'b1, 8'd13, 8'h3C, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);

        // Reset while a write is in flight with two entries queued
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'(8'h40 + i), 8'(8'h90 + i), 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);

        // Drop counter saturation
        repeat (270) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        check("drop_sat", 32'(bus.drop_cnt), 32'd255);
        repeat (2) cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // Random traffic with random stalls and occasional reset
        repeat (400)
            cycle($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 99) < 60, $urandom_range(0, 63) != 0);
        repeat (10) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
